// File: rtl/rf_writeback_queue_if.sv
// Bundle of the write-back push port, RF write port and bypass lookup port
// of rf_writeback_queue. The slave modport is the queue side.
interface rf_writeback_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wr_hold;
    logic              reg_write;
    logic [ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0] dst_data;
    logic [ADDR_W-1:0] lookup_addr;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;
    logic [CntW-1:0]   pending;

    modport master (
        output wb_valid, wb_addr, wb_data, wr_hold, lookup_addr,
        input  wb_ready, reg_write, dst_addr, dst_data, lookup_hit, lookup_data, pending
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, wr_hold, lookup_addr,
        output wb_ready, reg_write, dst_addr, dst_data, lookup_hit, lookup_data, pending
    );
endinterface

// File: rtl/rf_writeback_queue.sv
// Register-file write-back queue: in-order FIFO drained one write per cycle into a
// registered RF write port, with a combinational youngest-value bypass lookup.
module rf_writeback_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input logic                clk,
    input logic                rst_n,
    rf_writeback_queue_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e            state_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic              reg_write_q;
    logic [ADDR_W-1:0] dst_addr_q;
    logic [DATA_W-1:0] dst_data_q;
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic wb_ready;
    logic push;
    logic pop;

    // Readiness comes only from the registered count, so a same-cycle pop never frees a slot.
    assign wb_ready = (count_q < CntW'(DEPTH));
    assign push     = bus.wb_valid && wb_ready && (bus.wb_addr != '0);
    assign state_d  = ((count_q != '0) && !bus.wr_hold) ? StDrain : StIdle;
    assign pop      = (state_d == StDrain);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            reg_write_q <= 1'b0;
            dst_addr_q  <= '0;
            dst_data_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            unique case (state_d)
                StDrain: begin
                    rd_ptr_q    <= rd_ptr_q + PtrW'(1);
                    reg_write_q <= 1'b1;
                    dst_addr_q  <= addr_mem_q[rd_ptr_q];
                    dst_data_q  <= data_mem_q[rd_ptr_q];
                end
                default: reg_write_q <= 1'b0;
            endcase
        end
    end

    // Storage needs no reset: entries beyond count_q are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.wb_addr;
            data_mem_q[wr_ptr_q] <= bus.wb_data;
        end
    end

    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PtrW-1:0]   idx;

    // Walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        if (bus.lookup_addr != '0) begin
            if (reg_write_q && (dst_addr_q == bus.lookup_addr)) begin
                hit      = 1'b1;
                hit_data = dst_data_q;
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PtrW'(i);
                if ((CntW'(i) < count_q) && (addr_mem_q[idx] == bus.lookup_addr)) begin
                    hit      = 1'b1;
                    hit_data = data_mem_q[idx];
                end
            end
        end
    end

    assign bus.wb_ready    = wb_ready;
    assign bus.reg_write   = reg_write_q;
    assign bus.dst_addr    = dst_addr_q;
    assign bus.dst_data    = dst_data_q;
    assign bus.lookup_hit  = hit;
    assign bus.lookup_data = hit_data;
    assign bus.pending     = count_q;
endmodule
